// File: rtl/niu_alu_pkg.sv
// Shared definitions for the Niu32 ALU: secondary-opcode function codes and control FSM states.
package niu_alu_pkg;

    localparam logic [4:0] OP2_SUB = 5'b00000;
    localparam logic [4:0] OP2_ADD = 5'b00001;
    localparam logic [4:0] OP2_MLT = 5'b00010;
    localparam logic [4:0] OP2_DIV = 5'b00011;
    localparam logic [4:0] OP2_NOT = 5'b00100;
    localparam logic [4:0] OP2_AND = 5'b00101;
    localparam logic [4:0] OP2_OR  = 5'b00110;
    localparam logic [4:0] OP2_XOR = 5'b00111;
    localparam logic [4:0] OP2_SUL = 5'b01000;
    localparam logic [4:0] OP2_SSL = 5'b01001;
    localparam logic [4:0] OP2_SUR = 5'b01010;
    localparam logic [4:0] OP2_SSR = 5'b01011;
    localparam logic [4:0] OP2_EQ  = 5'b10000;
    localparam logic [4:0] OP2_NEQ = 5'b10001;
    localparam logic [4:0] OP2_LT  = 5'b10010;
    localparam logic [4:0] OP2_LEQ = 5'b10011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } alu_state_e;

endpackage

// File: rtl/niu_alu_comb.sv
// Single-cycle ALU ops (add/sub, logic, shifts, signed compares); purely combinational.
// Undefined function codes produce zero.
module niu_alu_comb
    import niu_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OP_BITS = 5
) (
    input  logic [OP_BITS-1:0] func,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   y
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (func)
            OP2_SUB:          y = a - b;
            OP2_ADD:          y = a + b;
            OP2_NOT:          y = ~a;
            OP2_AND:          y = a & b;
            OP2_OR:           y = a | b;
            OP2_XOR:          y = a ^ b;
            OP2_SUL, OP2_SSL: y = a << shamt;
            OP2_SUR:          y = a >> shamt;
            OP2_SSR:          y = $signed(a) >>> shamt;
            OP2_EQ:           y = {{(WIDTH-1){1'b0}}, a == b};
            OP2_NEQ:          y = {{(WIDTH-1){1'b0}}, a != b};
            OP2_LT:           y = {{(WIDTH-1){1'b0}}, $signed(a) <  $signed(b)};
            OP2_LEQ:          y = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(b)};
            default:          y = '0;
        endcase
    end

endmodule

// File: rtl/niu_iter_alu.sv
// Multicycle ALU: single-cycle ops and divide-by-zero complete in 1 cycle, MLT/DIV in WIDTH+2.
// No queueing: start is taken only in IDLE/DONE and is ignored while busy.
module niu_iter_alu
    import niu_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OP_BITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OP_BITS-1:0] func,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               dbz
);

    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    alu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  p_q, p_d;     // MUL accumulator / DIV partial remainder
    logic [WIDTH-1:0]  x_q, x_d;     // MUL multiplicand / DIV divisor magnitude
    logic [WIDTH-1:0]  y_q, y_d;     // MUL multiplier / DIV dividend shifting into quotient
    logic              neg_q, neg_d;
    logic              is_div_q, is_div_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              dbz_q, dbz_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [WIDTH-1:0]  comb_res;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    rem_sh, trial;

    niu_alu_comb #(.WIDTH(WIDTH), .OP_BITS(OP_BITS)) u_comb (
        .func (func),
        .a    (a),
        .b    (b),
        .y    (comb_res)
    );

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            neg_q    <= 1'b0;
            is_div_q <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            x_q      <= x_d;
            y_q      <= y_d;
            neg_q    <= neg_d;
            is_div_q <= is_div_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        x_d      = x_q;
        y_d      = y_q;
        neg_d    = neg_q;
        is_div_d = is_div_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        rem_sh   = {p_q, y_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, x_q};
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    cnt_d = '0;
                    p_d   = '0;
                    neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                    if (func == OP2_MLT) begin
                        state_d  = ST_MUL;
                        x_d      = a;
                        y_d      = b;
                        is_div_d = 1'b0;
                    end else if (func == OP2_DIV && b == '0) begin
                        state_d  = ST_DONE;
                        result_d = '1;
                        dbz_d    = 1'b1;
                    end else if (func == OP2_DIV) begin
                        state_d  = ST_DIV;
                        x_d      = b_mag;
                        y_d      = a_mag;
                        is_div_d = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = comb_res;
                        dbz_d    = 1'b0;
                    end
                end
            end
            ST_MUL: begin
                p_d   = p_q + (y_q[0] ? x_q : '0);
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = ST_FIX;
            end
            ST_DIV: begin
                // Restoring step: keep the subtraction only if it did not go negative.
                if (!trial[WIDTH]) begin
                    p_d = trial[WIDTH-1:0];
                    y_d = {y_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = rem_sh[WIDTH-1:0];
                    y_d = {y_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                result_d = is_div_q ? (neg_q ? -y_q : y_q) : p_q;
                dbz_d    = 1'b0;
                state_d  = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign dbz    = dbz_q;

endmodule

// File: tb/tb_niu_iter_alu.sv
// Randomized and directed bench for niu_iter_alu against a behavioural arithmetic model.
module tb_niu_iter_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [4:0]    func;
    logic [W-1:0]  a, b;
    logic          busy, done, dbz;
    logic [W-1:0]  result;

    int n_checks = 0;
    int n_err    = 0;

    niu_iter_alu #(.WIDTH(W), .OP_BITS(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .func   (func),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .dbz    (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Expected result, dbz flag and done latency straight from the operation definitions.
    function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] x,
                                          input logic [31:0] y, output bit z, output int lat);
        int     sx, sy, sh;
        longint prod;
        logic [63:0] pv;
        sx  = x;
        sy  = y;
        sh  = int'(y[4:0]);
        z   = 1'b0;
        lat = 1;
        case (f)
            5'b00000: model = x - y;
            5'b00001: model = x + y;
            5'b00010: begin
                prod  = longint'(sx) * longint'(sy);
                pv    = prod;
                model = pv[31:0];
                lat   = W + 2;
            end
            5'b00011: begin
                if (y == 0) begin
                    model = 32'hFFFF_FFFF;
                    z     = 1'b1;
                end else begin
                    lat = W + 2;
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = 32'h8000_0000;
                    else model = sx / sy;
                end
            end
            5'b00100: model = ~x;
            5'b00101: model = x & y;
            5'b00110: model = x | y;
            5'b00111: model = x ^ y;
            5'b01000, 5'b01001: model = x << sh;
            5'b01010: model = x >> sh;
            5'b01011: model = sx >>> sh;
            5'b10000: model = (sx == sy) ? 1 : 0;
            5'b10001: model = (sx != sy) ? 1 : 0;
            5'b10010: model = (sx <  sy) ? 1 : 0;
            5'b10011: model = (sx <= sy) ? 1 : 0;
            default:  model = 0;
        endcase
    endfunction

    // Issue one op; optionally pulse an ADD start 'inj' cycles in (must be ignored).
    task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] aa,
                          input logic [31:0] bb, input int inj);
        logic [31:0] er;
        bit          ez;
        int          el, lat, bcnt;
        er = model(f, aa, bb, ez, el);
        @(negedge clk);
        start = 1'b1; func = f; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0; func = 5'($urandom); a = $urandom; b = $urandom;
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (lat == inj) begin
                start = 1'b1; func = 5'b00001;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        check({tag, "_lat"}, lat, el);
        check({tag, "_res"}, result, er);
        check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, ez});
        check({tag, "_busycyc"}, bcnt, (el == 1) ? 0 : W + 1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic idle_check(input string tag, input logic [31:0] er);
        @(posedge clk); #1;
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, result, er);
    endtask

    logic [4:0] ops [16] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                             5'h08, 5'h09, 5'h0A, 5'h0B, 5'h10, 5'h11, 5'h12, 5'h13};

    initial begin
        int          ndone;
        logic [4:0]  rf;
        logic [31:0] ra, rb, er;
        bit          ez;
        int          el;

        reset = 1'b1; start = 1'b0; func = '0; a = '0; b = '0;
        #23;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dbz", {31'd0, dbz}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("add", 5'b00001, 32'd7, -32'sd3, 0);
        run_op("xor_b2b", 5'b00111, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        idle_check("xor", 32'h0FF0_0FF0);

        run_op("mlt_neg", 5'b00010, -32'sd6, 32'd7, 0);
        check("mlt_neg_val", result, 32'hFFFF_FFD6);
        run_op("mlt_ovf", 5'b00010, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("div_neg", 5'b00011, -32'sd7, 32'd2, 0);
        check("div_neg_val", result, 32'hFFFF_FFFD);
        run_op("div_zero", 5'b00011, 32'd5, 32'd0, 0);
        idle_check("div_zero", 32'hFFFF_FFFF);
        run_op("div_min", 5'b00011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("ssr", 5'b01011, 32'h8000_0000, 32'h24, 0);
        check("ssr_val", result, 32'hF800_0000);
        run_op("sur", 5'b01010, 32'h8000_0000, 32'h24, 0);
        run_op("sul", 5'b01000, 32'd1, 32'd31, 0);
        run_op("lt", 5'b10010, 32'hFFFF_FFFF, 32'd1, 0);
        check("lt_val", result, 32'd1);
        run_op("leq", 5'b10011, 32'd5, 32'd4, 0);
        run_op("eq", 5'b10000, 32'd9, 32'd9, 0);
        run_op("undef", 5'b11111, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        run_op("mlt_inj", 5'b00010, 32'd123457, -32'sd991, 5);
        idle_check("mlt_inj", 32'd123457 * -32'sd991);

        // Abort a divide with reset part-way through.
        @(negedge clk);
        start = 1'b1; func = 5'b00011; a = 32'd100000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("abort_no_done", ndone, 0);

        for (int i = 0; i < 60; i++) begin
            rf = ($urandom_range(0, 15) == 0) ? 5'($urandom) : ops[$urandom_range(0, 15)];
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 9)) - 32'd4;
                1:       rb = 32'($urandom_range(0, 63));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            er = model(rf, ra, rb, ez, el);
            run_op("rnd", rf, ra, rb, (el > 1 && $urandom_range(0, 3) == 0) ? 3 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
